// File: rtl/lsu_store_load_unit.sv
// Load/store unit between the core memory stage and a byte-wide data memory.
// Loads complete in one memory cycle; halfword/word stores are serialised into
// consecutive byte writes. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// halfword/word accesses into error responses.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_LOAD  | memory address/mode presented, read data captured on exit
// ST_STORE | one byte written per cycle, cnt_q selects the byte
// ST_RESP  | one-cycle response pulse (data, error)

module lsu_store_load_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_address_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_address_o,
    output logic [1:0]  mem_mode_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [23:0] wdata_q, wdata_d;       // bytes still to be written, next one in [7:0]
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;         // byte count minus one
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_mode_q, mem_mode_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic [1:0]  nbytes_m1;
    logic [32:0] last_addr;
    logic        out_of_range;
    logic        illegal;
    logic        misalign;
    logic        req_error;
    logic [31:0] load_data;

    // Request decode: width, legality and range of the incoming access
    always_comb begin
        case (req_funct3_i[1:0])
            2'b00:   nbytes_m1 = 2'd0;
            2'b01:   nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase
        // 33-bit sum so that addresses near 2^32 cannot wrap back into range
        last_addr    = {1'b0, req_address_i} + {31'b0, nbytes_m1};
        out_of_range = (last_addr >= 33'(MEM_BYTES));
        if (req_write_i) begin
            illegal = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3_i[1:0] == 2'b01) && req_address_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_address_i[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_error = illegal | out_of_range | misalign;
    end

    // Extract and extend load data from the memory read bus
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_data = funct3_q[2] ? {24'b0, mem_data_i[31:24]}
                                             : {{24{mem_data_i[31]}}, mem_data_i[31:24]};
            2'b01:   load_data = funct3_q[2] ? {16'b0, mem_data_i[31:16]}
                                             : {{16{mem_data_i[31]}}, mem_data_i[31:16]};
            default: load_data = mem_data_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_mode_d   = mem_mode_q;
        mem_data_d   = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    funct3_d    = req_funct3_i;
                    wdata_d     = req_wdata_i[31:8];
                    last_d      = nbytes_m1;
                    cnt_d       = 2'd0;
                    req_ready_d = 1'b0;
                    if (req_error) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'b0;
                    end else if (req_write_i) begin
                        state_d    = ST_STORE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = req_address_i;
                        mem_data_d = {24'b0, req_wdata_i[7:0]};
                    end else begin
                        state_d    = ST_LOAD;
                        mem_addr_d = req_address_i;
                        mem_mode_d = req_funct3_i[1:0];
                    end
                end
            end
            ST_LOAD: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = load_data;
            end
            ST_STORE: begin
                if (cnt_q == last_q) begin
                    state_d      = ST_RESP;
                    mem_we_d     = 1'b0;
                    mem_data_d   = 32'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = 32'b0;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_addr_d = mem_addr_q + 32'd1;
                    mem_data_d = {24'b0, wdata_q[7:0]};
                    wdata_d    = {8'b0, wdata_q[23:8]};
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            funct3_q     <= 3'b0;
            wdata_q      <= 24'b0;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_error_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_mode_q   <= 2'b10;
            mem_data_q   <= 32'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_mode_q   <= mem_mode_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign req_ready_o        = req_ready_q;
    assign resp_valid_o       = resp_valid_q;
    assign resp_rdata_o       = resp_rdata_q;
    assign resp_error_o       = resp_error_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_mode_o         = mem_mode_q;
    assign mem_data_o         = mem_data_q;

endmodule

// File: tb/tb_lsu_store_load_unit.sv
// Testbench for lsu_store_load_unit: directed table, reset-abort sequence and
// random requests checked against a byte-array reference model.

module tb_lsu_store_load_unit;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b0;
    logic [31:0] req_address_i = 32'b0;
    logic [31:0] req_wdata_i = 32'b0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_error_o;
    logic        mem_write_enable_o;
    logic [31:0] mem_address_o;
    logic [1:0]  mem_mode_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    lsu_store_load_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_write_i        (req_write_i),
        .req_funct3_i       (req_funct3_i),
        .req_address_i      (req_address_i),
        .req_wdata_i        (req_wdata_i),
        .resp_valid_o       (resp_valid_o),
        .resp_rdata_o       (resp_rdata_o),
        .resp_error_o       (resp_error_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_address_o      (mem_address_o),
        .mem_mode_o         (mem_mode_o),
        .mem_data_o         (mem_data_o),
        .mem_data_i         (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Physical memory seen by the DUT, and the reference model's own copy
    logic [7:0]  phys_mem [0:MEM_BYTES-1];
    logic [7:0]  ref_mem  [0:MEM_BYTES-1];
    logic [39:0] exp_wr_q [$];   // {address, byte} expected in order

    always_comb begin
        logic [9:0] a0;
        a0 = mem_address_o[9:0];
        case (mem_mode_o)
            2'b00:   mem_data_i = {phys_mem[a0], 24'h0};
            2'b01:   mem_data_i = {phys_mem[a0 + 10'd1], phys_mem[a0], 16'h0};
            default: mem_data_i = {phys_mem[a0 + 10'd3], phys_mem[a0 + 10'd2],
                                   phys_mem[a0 + 10'd1], phys_mem[a0]};
        endcase
    end

    // Outputs are held for a whole cycle, so the byte strobe is observed mid-cycle
    always @(negedge clk_i) begin
        if (mem_write_enable_o === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_write", {mem_address_o[23:0], mem_data_o[7:0]}, 32'h0);
            end else begin
                logic [39:0] e;
                e = exp_wr_q.pop_front();
                chk("write_addr", mem_address_o, e[39:8]);
                chk("write_byte", {24'b0, mem_data_o[7:0]}, {24'b0, e[7:0]});
                chk("write_upper_zero", {8'b0, mem_data_o[31:8]}, 32'h0);
            end
            if (mem_address_o < MEM_BYTES) phys_mem[mem_address_o[9:0]] = mem_data_o[7:0];
        end
    end

    // Reference model: derived from the access rules with plain arithmetic
    task automatic ref_model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output logic e_err, output int e_lat,
                             output logic [31:0] e_rd);
        int     n;
        bit     legal;
        bit     mis;
        longint last;
        longint v;
        case (f3[1:0])
            2'd0:    n = 1;
            2'd1:    n = 2;
            2'd2:    n = 4;
            default: n = 0;
        endcase
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        last  = longint'({32'b0, a}) + longint'(n) - 1;
        mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (n > 1) && ((a % n) != 0);
`endif
        e_rd = 32'h0;
        if (!legal || last >= longint'(MEM_BYTES) || mis) begin
            e_err = 1'b1;
            e_lat = 1;
        end else if (w) begin
            e_err = 1'b0;
            e_lat = n + 1;
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'((d >> (8 * i)) & 32'hFF);
                exp_wr_q.push_back({a + 32'(i), b});
                ref_mem[a + 32'(i)] = b;
            end
        end else begin
            e_err = 1'b0;
            e_lat = 2;
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_mem[a + 32'(i)]) << (8 * i);
            if (f3 < 3'd4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
            e_rd = v[31:0];
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic err,
                          output logic [31:0] rd);
        int wait_n;
        @(negedge clk_i);
        req_valid_i   = 1'b1;
        req_write_i   = w;
        req_funct3_i  = f3;
        req_address_i = a;
        req_wdata_i   = d;
        wait_n = 0;
        while (req_ready_o !== 1'b1 && wait_n < 50) begin
            @(negedge clk_i);
            wait_n++;
        end
        chk("ready_before_req", {31'b0, req_ready_o}, 32'h1);
        @(posedge clk_i);
        #1;
        req_valid_i   = 1'b0;
        req_write_i   = 1'($urandom);
        req_funct3_i  = 3'($urandom);
        req_address_i = $urandom;
        req_wdata_i   = $urandom;
        lat = 0;
        err = 1'b0;
        rd  = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (resp_valid_o === 1'b1) begin
                lat = n;
                err = resp_error_o;
                rd  = resp_rdata_o;
                break;
            end
            chk("ready_low_busy", {31'b0, req_ready_o}, 32'h0);
        end
        if (lat == 0) begin
            chk("resp_timeout", 32'h0, 32'h1);
        end else begin
            @(negedge clk_i);
            chk("resp_pulse_one_cycle", {31'b0, resp_valid_o}, 32'h0);
            chk("ready_after_resp", {31'b0, req_ready_o}, 32'h1);
        end
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(string nm, logic w, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] d, logic e, int l, logic [31:0] r);
        vec_t v;
        v.name = nm; v.w = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.e_err = e; v.e_lat = l; v.e_rd = r;
        return v;
    endfunction

    initial begin
        vec_t        tbl [$];
        logic        m_err, g_err;
        int          m_lat, g_lat;
        logic [31:0] m_rd, g_rd;

        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            phys_mem[i] = 8'h0;
            ref_mem[i]  = 8'h0;
        end

        tbl.push_back(mk("sw_0x10",   1, 3'b010, 32'h10, 32'h88913416, 0, 5, 32'h0));
        tbl.push_back(mk("lw_0x10",   0, 3'b010, 32'h10, 32'h0, 0, 2, 32'h88913416));
        tbl.push_back(mk("lb_0x13",   0, 3'b000, 32'h13, 32'h0, 0, 2, 32'hFFFFFF88));
        tbl.push_back(mk("lbu_0x13",  0, 3'b100, 32'h13, 32'h0, 0, 2, 32'h00000088));
        tbl.push_back(mk("lh_0x12",   0, 3'b001, 32'h12, 32'h0, 0, 2, 32'hFFFF8891));
        tbl.push_back(mk("lhu_0x12",  0, 3'b101, 32'h12, 32'h0, 0, 2, 32'h00008891));
        tbl.push_back(mk("sb_0x20",   1, 3'b000, 32'h20, 32'hAABBCCDD, 0, 2, 32'h0));
        tbl.push_back(mk("lw_0x20",   0, 3'b010, 32'h20, 32'h0, 0, 2, 32'h000000DD));
        tbl.push_back(mk("sh_0x40",   1, 3'b001, 32'h40, 32'h1234ABCD, 0, 3, 32'h0));
        tbl.push_back(mk("lhu_0x40",  0, 3'b101, 32'h40, 32'h0, 0, 2, 32'h0000ABCD));
        tbl.push_back(mk("ld_f3_011", 0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0));
        tbl.push_back(mk("ld_f3_110", 0, 3'b110, 32'h10, 32'h0, 1, 1, 32'h0));
        tbl.push_back(mk("st_f3_100", 1, 3'b100, 32'h10, 32'h0, 1, 1, 32'h0));
        tbl.push_back(mk("sw_0x3FE",  1, 3'b010, 32'h3FE, 32'h11223344, 1, 1, 32'h0));
        tbl.push_back(mk("sw_max",    1, 3'b010, 32'hFFFFFFFF, 32'h11223344, 1, 1, 32'h0));
        tbl.push_back(mk("lw_0x3FC",  0, 3'b010, 32'h3FC, 32'h0, 0, 2, 32'h0));
        tbl.push_back(mk("lw_0x3FD",  0, 3'b010, 32'h3FD, 32'h0, 1, 1, 32'h0));
        tbl.push_back(mk("sb_0x3FF",  1, 3'b000, 32'h3FF, 32'h000000A5, 0, 2, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back(mk("lh_0x11",   0, 3'b001, 32'h11, 32'h0, 1, 1, 32'h0));
`else
        tbl.push_back(mk("lh_0x11",   0, 3'b001, 32'h11, 32'h0, 0, 2, 32'hFFFF9134));
`endif

        // Reset values
        repeat (3) @(negedge clk_i);
        chk("rst_ready",      {31'b0, req_ready_o}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        chk("rst_resp_error", {31'b0, resp_error_o}, 32'h0);
        chk("rst_we",         {31'b0, mem_write_enable_o}, 32'h0);
        chk("rst_rdata",      resp_rdata_o, 32'h0);
        chk("rst_addr",       mem_address_o, 32'h0);
        chk("rst_data",       mem_data_o, 32'h0);
        chk("rst_mode",       {30'b0, mem_mode_o}, 32'h2);
        rst_i = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            ref_model(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_err, m_lat, m_rd);
            do_req(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wdata, g_lat, g_err, g_rd);
            chk({tbl[i].name, "_err"},   {31'b0, g_err}, {31'b0, tbl[i].e_err});
            chk({tbl[i].name, "_lat"},   32'(g_lat), 32'(tbl[i].e_lat));
            chk({tbl[i].name, "_rdata"}, g_rd, tbl[i].e_rd);
        end
        chk("table_writes_drained", 32'(exp_wr_q.size()), 32'h0);

        // Reset in the middle of SW 0x30: only the first two bytes land
        @(negedge clk_i);
        req_valid_i   = 1'b1;
        req_write_i   = 1'b1;
        req_funct3_i  = 3'b010;
        req_address_i = 32'h30;
        req_wdata_i   = 32'h44332211;
        exp_wr_q.push_back({32'h30, 8'h11});
        exp_wr_q.push_back({32'h31, 8'h22});
        ref_mem[32'h30] = 8'h11;
        ref_mem[32'h31] = 8'h22;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("abort_byte0_addr", mem_address_o, 32'h30);
        @(negedge clk_i);
        chk("abort_byte1_addr", mem_address_o, 32'h31);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_ready",      {31'b0, req_ready_o}, 32'h1);
        chk("abort_we",         {31'b0, mem_write_enable_o}, 32'h0);
        chk("abort_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("abort_no_resp", {31'b0, resp_valid_o}, 32'h0);
        end
        chk("abort_writes_drained", 32'(exp_wr_q.size()), 32'h0);
        ref_model(1'b0, 3'b010, 32'h30, 32'h0, m_err, m_lat, m_rd);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, g_lat, g_err, g_rd);
        chk("abort_lw_rdata", g_rd, 32'h00002211);
        chk("abort_lw_err",   {31'b0, g_err}, 32'h0);

        // Random requests against the reference model
        for (int it = 0; it < 250; it++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a, d;
            int          r;
            w  = 1'($urandom);
            f3 = 3'($urandom);
            d  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 3));
            else             a = 32'($urandom_range(0, MEM_BYTES - 1));
            ref_model(w, f3, a, d, m_err, m_lat, m_rd);
            do_req(w, f3, a, d, g_lat, g_err, g_rd);
            chk("rand_err",   {31'b0, g_err}, {31'b0, m_err});
            chk("rand_lat",   32'(g_lat), 32'(m_lat));
            chk("rand_rdata", g_rd, m_rd);
        end

        repeat (3) @(negedge clk_i);
        chk("final_writes_drained", 32'(exp_wr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
